// File: rtl/booth_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_GROUPS = 16;
  localparam int OP_W         = 32;
  localparam int PROD_W       = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic one;
    logic dbl;
    logic neg;
  } booth_sel_t;

  // Partial product already weighted by its group position; negative terms
  // come back one's-complemented, the +1 is supplied by the caller's carry-in.
  function automatic logic [PROD_W-1:0] booth_pp(input booth_sel_t s,
                                                 input logic [PROD_W-1:0] x,
                                                 input int unsigned sh);
    logic [PROD_W-1:0] mag;
    mag = s.dbl ? (x << (sh + 1)) : (s.one ? (x << sh) : '0);
    if (s.zero) mag = '0;
    return s.neg ? ~mag : mag;
  endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for booth_seq_mul.
interface booth_seq_mul_if;
  import booth_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [OP_W-1:0]   multiplicand;
  logic signed [OP_W-1:0]   multiplier;
  logic                     kill;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [PROD_W-1:0] product;

  modport master (
    output in_valid, multiplicand, multiplier, kill, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, kill, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/booth_seq_mul_enc.sv
// Radix-4 Booth group encoder: {b[2j+2], b[2j+1], b[2j]} -> digit select.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output booth_sel_t sel
);

  always_comb begin
    sel = '{zero: 1'b0, one: 1'b0, dbl: 1'b0, neg: 1'b0};
    unique case (grp)
      3'b000, 3'b111: sel.zero = 1'b1;
      3'b001, 3'b010: sel.one  = 1'b1;
      3'b011:         sel.dbl  = 1'b1;
      3'b100: begin
        sel.dbl = 1'b1;
        sel.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        sel.one = 1'b1;
        sel.neg = 1'b1;
      end
      default:        sel.zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative 32x32 signed radix-4 Booth multiplier retiring PP_PER_CYCLE
// partial products per busy cycle through a shared adder chain.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int PP_PER_CYCLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_seq_mul_if.slave bus
);

  localparam int PPC_SAFE = (PP_PER_CYCLE > 0) ? PP_PER_CYCLE : 1;
  localparam int N        = BOOTH_GROUPS / PPC_SAFE;
  localparam int SHIFT    = 2 * PPC_SAFE;
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  if (PP_PER_CYCLE != 1 && PP_PER_CYCLE != 2 && PP_PER_CYCLE != 4 &&
      PP_PER_CYCLE != 8 && PP_PER_CYCLE != 16) begin : g_bad_pp
    $fatal(1, "booth_seq_mul: PP_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e                   state;
  logic signed [PROD_W-1:0] mcand;
  logic signed [PROD_W-1:0] acc;
  logic signed [OP_W:0]     mplier;
  logic [3:0]               cnt;

  booth_sel_t               sel [PPC_SAFE];
  logic [PROD_W-1:0]        pp  [PPC_SAFE];
  logic [PROD_W-1:0]        acc_next;

  for (genvar j = 0; j < PPC_SAFE; j++) begin : g_grp
    booth_enc u_enc (
      .grp (mplier[2*j+2 -: 3]),
      .sel (sel[j])
    );
    assign pp[j] = booth_pp(sel[j], mcand, 2 * j);
  end

  // Each negative digit contributes its two's-complement +1 as a carry-in.
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < PPC_SAFE; j++) begin
      acc_next = acc_next + pp[j] + {{(PROD_W-1){1'b0}}, sel[j].neg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid && !bus.kill) begin
            mcand  <= {{(PROD_W-OP_W){bus.multiplicand[OP_W-1]}}, bus.multiplicand};
            mplier <= {bus.multiplier, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.kill) begin
            state <= ST_IDLE;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >>> SHIFT;
            mcand  <= mcand << SHIFT;
            cnt    <= cnt + 4'd1;
            if (cnt == CNT_LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.kill || bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Product is only exposed in DONE so no partial sum ever reaches the port.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.product   = (state == ST_DONE) ? acc : '0;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul: vector table, handshake corner
// sequences, latency across all PP_PER_CYCLE values and randomized traffic.
module tb_booth_seq_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  booth_seq_mul_if bus ();

  booth_seq_mul #(.PP_PER_CYCLE(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One instance per legal PP_PER_CYCLE, driven by shared stimulus.
  logic        lv;
  logic [31:0] la, lb;
  logic        lat_ov  [5];
  logic        lat_rdy [5];
  logic [63:0] lat_prod[5];

  for (genvar k = 0; k < 5; k++) begin : g_lat
    booth_seq_mul_if lif ();
    assign lif.in_valid     = lv;
    assign lif.multiplicand = la;
    assign lif.multiplier   = lb;
    assign lif.kill         = 1'b0;
    assign lif.out_ready    = 1'b1;
    assign lat_ov[k]   = lif.out_valid;
    assign lat_rdy[k]  = lif.in_ready;
    assign lat_prod[k] = lif.product;
    booth_seq_mul #(.PP_PER_CYCLE(1 << k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (lif)
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat);
    issue(a, b);
    wait_out(lat);
    p = bus.product;
    consume();
  endtask

  function automatic logic [63:0] ref_mul(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    longint r;
    r = longint'(a) * longint'(b);
    return 64'(r);
  endfunction

  localparam int NRAND = 3000;

  initial begin
    logic [63:0] p;
    logic [63:0] held;
    logic [63:0] expq[$];
    logic        ov_seen;
    int          lat;
    int          seen[5];
    logic [63:0] got[5];
    int          sent, recv, cyc;
    logic signed [31:0] ra, rb;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'd7,         32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[5] = '{32'd0,         32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[7] = '{32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.kill         = 1'b0;
    bus.out_ready    = 1'b0;
    lv = 1'b0;
    la = '0;
    lb = '0;

    #12;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_product",   bus.product,        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency of 3x5 for every legal PP_PER_CYCLE.
    for (int k = 0; k < 5; k++) begin
      seen[k] = -1;
      got[k]  = '0;
      check($sformatf("lat_rdy_%0d", k), 64'(lat_rdy[k]), 64'd1);
    end
    @(negedge clk);
    lv = 1'b1;
    la = 32'd3;
    lb = 32'd5;
    @(posedge clk);
    #1;
    lv = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
        if (lat_ov[k] && seen[k] < 0) begin
          seen[k] = c;
          got[k]  = lat_prod[k];
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("lat_cycles_pp%0d", 1 << k), 64'(seen[k]), 64'(16 >> k));
      check($sformatf("lat_prod_pp%0d", 1 << k), got[k], 64'h0F);
    end

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].p);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
    end

    // Backpressure in DONE, then back-to-back acceptance.
    issue(32'd1000, 32'hFFFF_FF9C);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd8);
    held = bus.product;
    check("bp_first_product", held, 64'hFFFF_FFFF_FFFE_7960);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_product",   bus.product,        held);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_ready_after_hs", 64'(bus.in_ready),  64'd1);
    check("bp_valid_after_hs", 64'(bus.out_valid), 64'd0);
    bus.in_valid     = 1'b1;
    bus.multiplicand = 32'd11;
    bus.multiplier   = 32'd13;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_accepted", 64'(bus.in_ready), 64'd0);
    wait_out(lat);
    check("bp_next_latency", 64'(lat), 64'd8);
    check("bp_next_product", bus.product, 64'd143);
    consume();

    // Kill at BUSY cycle 3.
    issue(32'd1234, 32'd5678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_idle",      64'(bus.in_ready),  64'd1);
    check("kill_out_valid", 64'(bus.out_valid), 64'd0);
    ov_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      ov_seen |= bus.out_valid;
    end
    check("kill_no_product", 64'(ov_seen), 64'd0);
    // kill beats a same-cycle input handshake in IDLE
    @(negedge clk);
    bus.kill     = 1'b1;
    bus.in_valid = 1'b1;
    bus.multiplicand = 32'd99;
    bus.multiplier   = 32'd99;
    @(posedge clk);
    #1;
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_idle_discard", 64'(bus.in_ready), 64'd1);
    run_op(32'd7, 32'hFFFF_FFFA, p, lat);
    check("kill_after_product", p, 64'hFFFF_FFFF_FFFF_FFD6);

    // Asynchronous reset mid-BUSY.
    issue(32'd123, 32'd456);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstb_in_ready",  64'(bus.in_ready),  64'd1);
    check("rstb_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstb_product",   bus.product,        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd2, p, lat);
    check("rstb_after_product", p, 64'd4);

    // Asynchronous reset while a result is waiting in DONE.
    issue(32'd9, 32'd9);
    wait_out(lat);
    check("rstd_product_before", bus.product, 64'd81);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstd_out_valid", 64'(bus.out_valid), 64'd0);
    check("rstd_product",   bus.product,        64'd0);
    check("rstd_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with stalls on both sides.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < NRAND && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0: ra = 32'h8000_0000;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        3: rb = 32'hFFFF_FFFF;
        4: rb = '0;
        default: ;
      endcase
      bus.in_valid     = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      bus.multiplicand = ra;
      bus.multiplier   = rb;
      bus.out_ready    = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_mul(ra, rb));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("rand_unexpected_output", bus.product, 64'hXXXX_XXXX_XXXX_XXXX);
        end else begin
          check("rand_product", bus.product, expq.pop_front());
        end
        recv++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_received", 64'(recv), 64'(NRAND));
    check("rand_queue_empty", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
